// File: rtl/prediction_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prediction_controller_pkg
// Description : Shared constants and the FSM state encoding for the
//               prediction controller and its argmax unit.
//               Contents: NUM_CLASSES (scores per frame), DIGIT_W (digit
//               width), state_t (controller FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package prediction_controller_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DIGIT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/predict_digit.sv
`default_nettype none
// ============================================================================
// Module      : predict_digit
// Description : Pipelined argmax over NUM_CLASSES signed scores. Score of
//               digit d sits in slot (NUM_CLASSES-1-d) of the packed input.
//               Ties resolve to the lower digit. done pulses 5 cycles after
//               start is sampled, together with predicted_digit.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               start                - sample scores this cycle
//               scores               - packed score vector
//               done                 - one-cycle result strobe
//               predicted_digit      - index of the largest score
// Revision    : 1.0 - initial release
// ============================================================================
module predict_digit
  import prediction_controller_pkg::*;
#(
  parameter int WIDTH = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_CLASSES*WIDTH-1:0] scores,
  output logic                         done,
  output logic [DIGIT_W-1:0]           predicted_digit
);

  // Reduction tree 10 -> 5 -> 3 -> 2 -> 1, one register level per step.
  logic signed [WIDTH-1:0] r_s1_sc [NUM_CLASSES];
  logic signed [WIDTH-1:0] r_s2_sc [5];
  logic [DIGIT_W-1:0]      r_s2_dg [5];
  logic signed [WIDTH-1:0] r_s3_sc [3];
  logic [DIGIT_W-1:0]      r_s3_dg [3];
  logic signed [WIDTH-1:0] r_s4_sc [2];
  logic [DIGIT_W-1:0]      r_s4_dg [2];
  logic [DIGIT_W-1:0]      r_s5_dg;
  logic [4:0]              r_vld;

  // Operand a always carries the lower digit, so strict '>' keeps ties low.
  function automatic logic b_wins(input logic signed [WIDTH-1:0] a,
                                  input logic signed [WIDTH-1:0] b);
    return b > a;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld           <= '0;
      done            <= 1'b0;
      predicted_digit <= '0;
      r_s5_dg         <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) r_s1_sc[i] <= '0;
      for (int i = 0; i < 5; i++) begin
        r_s2_sc[i] <= '0;
        r_s2_dg[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        r_s3_sc[i] <= '0;
        r_s3_dg[i] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        r_s4_sc[i] <= '0;
        r_s4_dg[i] <= '0;
      end
    end else begin
      r_vld <= {r_vld[3:0], start};

      for (int d = 0; d < NUM_CLASSES; d++)
        r_s1_sc[d] <= scores[(NUM_CLASSES-1-d)*WIDTH +: WIDTH];

      for (int i = 0; i < 5; i++) begin
        if (b_wins(r_s1_sc[2*i], r_s1_sc[2*i+1])) begin
          r_s2_sc[i] <= r_s1_sc[2*i+1];
          r_s2_dg[i] <= DIGIT_W'(2*i+1);
        end else begin
          r_s2_sc[i] <= r_s1_sc[2*i];
          r_s2_dg[i] <= DIGIT_W'(2*i);
        end
      end

      for (int i = 0; i < 2; i++) begin
        if (b_wins(r_s2_sc[2*i], r_s2_sc[2*i+1])) begin
          r_s3_sc[i] <= r_s2_sc[2*i+1];
          r_s3_dg[i] <= r_s2_dg[2*i+1];
        end else begin
          r_s3_sc[i] <= r_s2_sc[2*i];
          r_s3_dg[i] <= r_s2_dg[2*i];
        end
      end
      r_s3_sc[2] <= r_s2_sc[4];
      r_s3_dg[2] <= r_s2_dg[4];

      if (b_wins(r_s3_sc[0], r_s3_sc[1])) begin
        r_s4_sc[0] <= r_s3_sc[1];
        r_s4_dg[0] <= r_s3_dg[1];
      end else begin
        r_s4_sc[0] <= r_s3_sc[0];
        r_s4_dg[0] <= r_s3_dg[0];
      end
      r_s4_sc[1] <= r_s3_sc[2];
      r_s4_dg[1] <= r_s3_dg[2];

      r_s5_dg <= b_wins(r_s4_sc[0], r_s4_sc[1]) ? r_s4_dg[1] : r_s4_dg[0];

      done            <= r_vld[4];
      predicted_digit <= r_s5_dg;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prediction_controller.sv
`default_nettype none
// ============================================================================
// Module      : prediction_controller
// Description : Collects one frame of 10 scores (digit order 0..9), launches
//               the argmax unit, waits for its result under a watchdog and
//               presents {digit, score} on a valid/ready port.
// Ports       : clk, reset                      - clock, sync active-high reset
//               score_valid/ready/data/last     - score input stream
//               abort                           - drop the frame in flight
//               result_valid/ready/digit/score  - result output
//               busy                            - high whenever not IDLE
//               error                           - sticky frame/timeout error
// Revision    : 1.0 - initial release
// ============================================================================
module prediction_controller #(
  parameter int WIDTH       = 40,
  parameter int NUM_CLASSES = 10,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             score_valid,
  output logic             score_ready,
  input  logic [WIDTH-1:0] score_data,
  input  logic             score_last,
  input  logic             abort,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [3:0]       result_digit,
  output logic [WIDTH-1:0] result_score,
  output logic             busy,
  output logic             error
);
  import prediction_controller_pkg::*;

  generate
    if (NUM_CLASSES != prediction_controller_pkg::NUM_CLASSES) begin : g_bad_num_classes
      $error("prediction_controller: NUM_CLASSES must be 10");
    end
  endgenerate

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t                       r_state;
  logic [3:0]                   r_count;
  logic [NUM_CLASSES*WIDTH-1:0] r_buf;
  logic [WD_W-1:0]              r_wd;

  logic                         w_hs;
  logic [3:0]                   w_slot;
  logic                         w_start;
  logic                         w_done;
  logic [DIGIT_W-1:0]           w_pred;
  logic [WIDTH-1:0]             w_win_score;

  assign w_hs    = score_valid & score_ready;
  assign w_slot  = LAST_IDX - r_count;
  // An abort in LAUNCH must not fire the argmax unit.
  assign w_start = (r_state == ST_LAUNCH) & ~abort;

  predict_digit #(
    .WIDTH(WIDTH)
  ) u_predict_digit (
    .clk            (clk),
    .reset          (reset),
    .start          (w_start),
    .scores         (r_buf),
    .done           (w_done),
    .predicted_digit(w_pred)
  );

  // Winning score is read back from the buffer slot of the predicted digit.
  always_comb begin
    w_win_score = '0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (w_pred == 4'(NUM_CLASSES - 1 - i)) w_win_score = r_buf[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_buf        <= '0;
      r_wd         <= '0;
      score_ready  <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= '0;
      result_score <= '0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      // Storing on an aborted handshake is harmless: every launched frame
      // rewrites all slots first.
      if (w_hs) begin
        for (int i = 0; i < NUM_CLASSES; i++)
          if (w_slot == 4'(i)) r_buf[i*WIDTH +: WIDTH] <= score_data;
      end

      case (r_state)
        ST_IDLE: begin
          score_ready <= 1'b1;
          if (w_hs) begin
            if (score_last) begin
              // A one-score frame is as short as any other short frame.
              error <= 1'b1;
            end else begin
              r_count <= 4'd1;
              r_state <= ST_COLLECT;
              busy    <= 1'b1;
            end
          end
        end

        ST_COLLECT: begin
          if (abort) begin
            r_count <= '0;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (w_hs) begin
            if (r_count == LAST_IDX && score_last) begin
              r_count     <= '0;
              r_state     <= ST_LAUNCH;
              score_ready <= 1'b0;
            end else if (r_count == LAST_IDX || score_last) begin
              error   <= 1'b1;
              r_count <= '0;
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              r_count <= r_count + 4'd1;
            end
          end
        end

        ST_LAUNCH: begin
          if (abort) begin
            r_state     <= ST_IDLE;
            score_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            r_wd    <= '0;
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            r_state     <= ST_IDLE;
            score_ready <= 1'b1;
            busy        <= 1'b0;
          end else if (w_done) begin
            result_digit <= w_pred;
            result_score <= w_win_score;
            result_valid <= 1'b1;
            r_state      <= ST_HOLD;
          end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
            error       <= 1'b1;
            r_state     <= ST_IDLE;
            score_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end

        ST_HOLD: begin
          if (abort || result_ready) begin
            result_valid <= 1'b0;
            r_state      <= ST_IDLE;
            score_ready  <= 1'b1;
            busy         <= 1'b0;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_count      <= '0;
          score_ready  <= 1'b1;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
